// File: rtl/cnn_pkg.sv
// cnn_pkg
// Shared definitions for the convolution sequencer: window geometry,
// legal configuration limits, FSM state encoding and a config check.
// No ports (package).
package cnn_pkg;

    localparam int K        = 3;
    localparam int TAPS     = 9;
    localparam int MAX_DIM  = 32;
    localparam int MAX_FILT = 4;

    // State encoding, kept as plain constants for legacy tool flows.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_READ  = 3'd1;
    localparam state_t ST_WAIT  = 3'd2;
    localparam state_t ST_WRITE = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    // A layer needs at least one full 3x3 window and at least one filter.
    function automatic logic cfg_legal(input logic [5:0] dim, input logic [2:0] nf);
        return (dim >= 6'(K)) && (dim <= 6'(MAX_DIM)) &&
               (nf != 3'd0) && (nf <= 3'(MAX_FILT));
    endfunction

endpackage

// File: rtl/cnn_win_addr_gen.sv
// cnn_win_addr_gen
// Walks the 3x3 window taps and the output pixel raster, producing the
// feature-map read address and the result write address incrementally
// (adds only, no multiplier).
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   clear              return all counters/addresses to zero (wins over strobes)
//   advance_tap        step to the next tap of the current window
//   advance_pix        step to the next output pixel (c, then r)
//   dim                latched input side length
//   rd_addr, wr_addr   registered read / write addresses
//   tap_idx            current tap 0..8
//   tap_last           current tap is 8
//   pix_last_rc        current pixel is the last of the raster (r=c=od-1)
module cnn_win_addr_gen
    import cnn_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              advance_tap,
    input  logic              advance_pix,
    input  logic [5:0]        dim,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [3:0]        tap_idx,
    output logic              tap_last,
    output logic              pix_last_rc
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    logic [1:0]        kx_q, kx_d, ky_q, ky_d;
    logic [3:0]        tap_q, tap_d;
    logic [4:0]        r_q, r_d, c_q, c_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;   // r*dim
    logic [ADDR_W-1:0] pix_base_q, pix_base_d;   // r*dim + c, window top-left
    logic [ADDR_W-1:0] win_row_q, win_row_d;     // pix_base + ky*dim
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;

    logic [ADDR_W-1:0] dim_w;
    logic [5:0]        od_m1;
    logic              c_last, r_last;

    assign dim_w  = {{(ADDR_W-6){1'b0}}, dim};
    assign od_m1  = dim - 6'd3;
    assign c_last = ({1'b0, c_q} == od_m1);
    assign r_last = ({1'b0, r_q} == od_m1);

    always_comb begin
        kx_d       = kx_q;
        ky_d       = ky_q;
        tap_d      = tap_q;
        r_d        = r_q;
        c_d        = c_q;
        row_base_d = row_base_q;
        pix_base_d = pix_base_q;
        win_row_d  = win_row_q;
        rd_addr_d  = rd_addr_q;
        wr_addr_d  = wr_addr_q;
        if (clear) begin
            kx_d       = '0;
            ky_d       = '0;
            tap_d      = '0;
            r_d        = '0;
            c_d        = '0;
            row_base_d = '0;
            pix_base_d = '0;
            win_row_d  = '0;
            rd_addr_d  = '0;
            wr_addr_d  = '0;
        end else if (advance_tap) begin
            if (kx_q != 2'(K-1)) begin
                kx_d      = kx_q + 2'd1;
                tap_d     = tap_q + 4'd1;
                rd_addr_d = rd_addr_q + ADDR_ONE;
            end else if (ky_q != 2'(K-1)) begin
                kx_d      = '0;
                ky_d      = ky_q + 2'd1;
                tap_d     = tap_q + 4'd1;
                win_row_d = win_row_q + dim_w;
                rd_addr_d = win_row_q + dim_w;
            end else begin
                // Window finished; park on its top-left until the pixel advances.
                kx_d      = '0;
                ky_d      = '0;
                tap_d     = '0;
                win_row_d = pix_base_q;
                rd_addr_d = pix_base_q;
            end
        end else if (advance_pix) begin
            // Raster order is c, r, f, so the write address is just a running count.
            wr_addr_d = wr_addr_q + ADDR_ONE;
            if (!c_last) begin
                c_d        = c_q + 5'd1;
                pix_base_d = pix_base_q + ADDR_ONE;
            end else if (!r_last) begin
                c_d        = '0;
                r_d        = r_q + 5'd1;
                row_base_d = row_base_q + dim_w;
                pix_base_d = row_base_q + dim_w;
            end else begin
                // Next filter revisits the same input pixels.
                c_d        = '0;
                r_d        = '0;
                row_base_d = '0;
                pix_base_d = '0;
            end
            win_row_d = pix_base_d;
            rd_addr_d = pix_base_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            kx_q       <= '0;
            ky_q       <= '0;
            tap_q      <= '0;
            r_q        <= '0;
            c_q        <= '0;
            row_base_q <= '0;
            pix_base_q <= '0;
            win_row_q  <= '0;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
        end else begin
            kx_q       <= kx_d;
            ky_q       <= ky_d;
            tap_q      <= tap_d;
            r_q        <= r_d;
            c_q        <= c_d;
            row_base_q <= row_base_d;
            pix_base_q <= pix_base_d;
            win_row_q  <= win_row_d;
            rd_addr_q  <= rd_addr_d;
            wr_addr_q  <= wr_addr_d;
        end
    end

    assign rd_addr     = rd_addr_q;
    assign wr_addr     = wr_addr_q;
    assign tap_idx     = tap_q;
    assign tap_last    = (tap_q == 4'(TAPS-1));
    assign pix_last_rc = c_last && r_last;

endmodule

// File: rtl/cnn_conv_sequencer.sv
// cnn_conv_sequencer
// Sequences one shared 3x3 MAC engine across a convolution layer: per output
// pixel it issues 9 tap reads, waits MAC_LAT cycles, then one result write.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   start, abort                  layer start / cancel
//   in_dim, num_filt              layer config, latched on accepted start
//   busy, done, cfg_err           status (done, cfg_err are one-cycle pulses)
//   rd_valid/rd_ready/rd_addr     tap read handshake
//   tap_idx, filt_idx             weight select
//   mac_clear, mac_last           MAC accumulation framing
//   wr_valid/wr_ready/wr_addr     result write handshake
//
// state | meaning
// IDLE  | waiting for start; counters held cleared
// READ  | issuing the 9 tap reads of the current window
// WAIT  | MAC pipeline draining (down-counter from MAC_LAT-1)
// WRITE | result write pending
// DONE  | one-cycle completion pulse
module cnn_conv_sequencer
    import cnn_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int MAC_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [5:0]        in_dim,
    input  logic [2:0]        num_filt,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [3:0]        tap_idx,
    output logic [2:0]        filt_idx,
    output logic              mac_clear,
    output logic              mac_last,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr
);

    state_t     state_q, state_d;
    logic [5:0] dim_q, dim_d;
    logic [2:0] nf_q, nf_d;
    logic [2:0] f_q, f_d;
    logic [2:0] wait_q, wait_d;
    logic       cfg_err_q, cfg_err_d;

    logic       adv_tap, adv_pix, gen_clear;
    logic       tap_last, pix_last_rc;

    always_comb begin
        state_d   = state_q;
        dim_d     = dim_q;
        nf_d      = nf_q;
        f_d       = f_q;
        wait_d    = wait_q;
        cfg_err_d = 1'b0;
        adv_tap   = 1'b0;
        adv_pix   = 1'b0;
        gen_clear = (state_q == ST_IDLE) || abort;
        if (abort) begin
            // Also covers abort arriving together with start in IDLE.
            state_d = ST_IDLE;
            f_d     = '0;
            wait_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    f_d = '0;
                    if (start) begin
                        if (cfg_legal(in_dim, num_filt)) begin
                            state_d = ST_READ;
                            dim_d   = in_dim;
                            nf_d    = num_filt;
                        end else begin
                            cfg_err_d = 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (rd_ready) begin
                        adv_tap = 1'b1;
                        if (tap_last) begin
                            state_d = ST_WAIT;
                            wait_d  = 3'(MAC_LAT-1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_q == 3'd0) begin
                        state_d = ST_WRITE;
                    end else begin
                        wait_d = wait_q - 3'd1;
                    end
                end
                ST_WRITE: begin
                    if (wr_ready) begin
                        adv_pix = 1'b1;
                        state_d = ST_READ;
                        if (pix_last_rc) begin
                            if (f_q == nf_q - 3'd1) begin
                                state_d = ST_DONE;
                            end else begin
                                f_d = f_q + 3'd1;
                            end
                        end
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            dim_q     <= '0;
            nf_q      <= '0;
            f_q       <= '0;
            wait_q    <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dim_q     <= dim_d;
            nf_q      <= nf_d;
            f_q       <= f_d;
            wait_q    <= wait_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    cnn_win_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .clear       (gen_clear),
        .advance_tap (adv_tap),
        .advance_pix (adv_pix),
        .dim         (dim_q),
        .rd_addr     (rd_addr),
        .wr_addr     (wr_addr),
        .tap_idx     (tap_idx),
        .tap_last    (tap_last),
        .pix_last_rc (pix_last_rc)
    );

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign cfg_err   = cfg_err_q;
    assign rd_valid  = (state_q == ST_READ);
    assign wr_valid  = (state_q == ST_WRITE);
    assign filt_idx  = f_q;
    assign mac_clear = rd_valid && (tap_idx == 4'd0);
    assign mac_last  = rd_valid && tap_last;

endmodule

// File: tb/tb_cnn_conv_sequencer.sv
module tb_cnn_conv_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [5:0]  in_dim;
    logic [2:0]  num_filt;
    logic        busy, done, cfg_err;
    logic        rd_valid, rd_ready;
    logic [11:0] rd_addr;
    logic [3:0]  tap_idx;
    logic [2:0]  filt_idx;
    logic        mac_clear, mac_last;
    logic        wr_valid, wr_ready;
    logic [11:0] wr_addr;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [11:0] addr;
        logic [3:0]  tap;
        logic [2:0]  filt;
    } rd_exp_t;

    typedef struct packed {
        logic [11:0] addr;
        logic [2:0]  filt;
    } wr_exp_t;

    rd_exp_t rd_q[$];
    wr_exp_t wr_q[$];

    cnn_conv_sequencer #(.ADDR_W(12), .MAC_LAT(2)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .in_dim(in_dim), .num_filt(num_filt),
        .busy(busy), .done(done), .cfg_err(cfg_err),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .tap_idx(tap_idx), .filt_idx(filt_idx),
        .mac_clear(mac_clear), .mac_last(mac_last),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr)
    );

    always #5 clk = ~clk;

    // Reference raster: every filter, every output pixel, every tap, straight from the address formulas.
    task automatic push_expect(input int dim, input int nf);
        int od;
        rd_exp_t re;
        wr_exp_t we;
        od = dim - 2;
        for (int f = 0; f < nf; f++)
            for (int r = 0; r < od; r++)
                for (int c = 0; c < od; c++) begin
                    for (int ky = 0; ky < 3; ky++)
                        for (int kx = 0; kx < 3; kx++) begin
                            re.addr = 12'((r + ky) * dim + c + kx);
                            re.tap  = 4'(3 * ky + kx);
                            re.filt = 3'(f);
                            rd_q.push_back(re);
                        end
                    we.addr = 12'(f * od * od + r * od + c);
                    we.filt = 3'(f);
                    wr_q.push_back(we);
                end
    endtask

    // Runs one layer; edges are numbered with the start-sampling edge as 0.
    task automatic drive_layer(input int dim, input int nf, input int rd_stall_tap, input int rd_stall_n,
                               input int wr_stall_n, output int clr_edge, output int last_edge,
                               output int wr_edge, output int done_edge);
        int      edge_n, rd_stalls, wr_stalls;
        bit      fin;
        rd_exp_t re;
        wr_exp_t we;
        rd_q.delete();
        wr_q.delete();
        push_expect(dim, nf);
        clr_edge = -1; last_edge = -1; wr_edge = -1; done_edge = -1;
        rd_stalls = 0; wr_stalls = 0; fin = 1'b0;
        @(negedge clk);
        in_dim = 6'(dim); num_filt = 3'(nf); start = 1'b1; rd_ready = 1'b1; wr_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; in_dim = 6'd2; num_filt = 3'd0;   // config must already be latched
        edge_n = 1;
        while (!fin && edge_n < 5000) begin
            rd_ready = 1'b1;
            wr_ready = 1'b1;
            re = (rd_q.size() != 0) ? rd_q[0] : '1;
            we = (wr_q.size() != 0) ? wr_q[0] : '1;
            if (rd_valid && rd_stall_tap >= 0 && wr_edge < 0 && tap_idx == 4'(rd_stall_tap)
                && rd_stalls < rd_stall_n) begin
                rd_ready = 1'b0;
                rd_stalls++;
                total++;
                if (rd_addr !== re.addr || tap_idx !== re.tap) begin
                    bad++;
                    $display("FAIL rd_hold edge %0d: addr=%0d tap=%0d, want addr=%0d tap=%0d",
                             edge_n, rd_addr, tap_idx, re.addr, re.tap);
                end
            end
            if (wr_valid && wr_stalls < wr_stall_n) begin
                wr_ready = 1'b0;
                wr_stalls++;
                total++;
                if (rd_valid !== 1'b0 || wr_addr !== we.addr) begin
                    bad++;
                    $display("FAIL wr_hold edge %0d: rd_valid=%0b wr_addr=%0d, want rd_valid=0 wr_addr=%0d",
                             edge_n, rd_valid, wr_addr, we.addr);
                end
            end
            if (rd_valid && rd_ready) begin
                total++;
                if (mac_clear && clr_edge < 0) clr_edge = edge_n;
                if (mac_last && last_edge < 0) last_edge = edge_n;
                if (rd_q.size() == 0) begin
                    bad++;
                    $display("FAIL rd_extra edge %0d: addr=%0d, want no read", edge_n, rd_addr);
                end else begin
                    re = rd_q.pop_front();
                    if (rd_addr !== re.addr || tap_idx !== re.tap || filt_idx !== re.filt ||
                        mac_clear !== (re.tap == 4'd0) || mac_last !== (re.tap == 4'd8)) begin
                        bad++;
                        $display("FAIL rd_beat edge %0d: addr=%0d tap=%0d f=%0d clr=%0b last=%0b, want addr=%0d tap=%0d f=%0d",
                                 edge_n, rd_addr, tap_idx, filt_idx, mac_clear, mac_last, re.addr, re.tap, re.filt);
                    end
                end
            end
            if (wr_valid && wr_ready) begin
                total++;
                if (wr_edge < 0) wr_edge = edge_n;
                if (wr_q.size() == 0) begin
                    bad++;
                    $display("FAIL wr_extra edge %0d: addr=%0d, want no write", edge_n, wr_addr);
                end else begin
                    we = wr_q.pop_front();
                    if (wr_addr !== we.addr || filt_idx !== we.filt) begin
                        bad++;
                        $display("FAIL wr_beat edge %0d: addr=%0d f=%0d, want addr=%0d f=%0d",
                                 edge_n, wr_addr, filt_idx, we.addr, we.filt);
                    end
                end
            end
            if (done) begin
                done_edge = edge_n;
                fin = 1'b1;
            end else begin
                @(negedge clk);
                edge_n++;
            end
        end
        total++;
        if (!fin || rd_q.size() != 0 || wr_q.size() != 0) begin
            bad++;
            $display("FAIL layer_end dim=%0d: done_seen=%0b rd_left=%0d wr_left=%0d, want 1 0 0",
                     dim, fin, rd_q.size(), wr_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; abort = 1'b0; in_dim = 6'd3; num_filt = 3'd1;
        rd_ready = 1'b1; wr_ready = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, cfg_err, rd_valid, mac_clear, mac_last, wr_valid} !== 7'b0 ||
            rd_addr !== 12'd0 || wr_addr !== 12'd0 || tap_idx !== 4'd0 || filt_idx !== 3'd0) begin
            bad++;
            $display("FAIL reset_state: busy=%0b done=%0b rdv=%0b wrv=%0b rd_addr=%0d wr_addr=%0d, want all 0",
                     busy, done, rd_valid, wr_valid, rd_addr, wr_addr);
        end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_over_start: busy=%0b, want 0", busy);
        end
    endtask

    task automatic test_single_pixel();
        int ce, le, we, de;
        drive_layer(3, 1, -1, 0, 0, ce, le, we, de);
        total++;
        if (ce != 1 || le != 9 || we != 12 || de != 13) begin
            bad++;
            $display("FAIL single_timing: clear@%0d last@%0d write@%0d done@%0d, want 1 9 12 13", ce, le, we, de);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL single_idle: busy=%0b done=%0b at edge 14, want 0 0", busy, done);
        end
    endtask

    task automatic test_multi_filter();
        int ce, le, we, de;
        drive_layer(4, 2, -1, 0, 0, ce, le, we, de);
        total++;
        if (de != 97) begin
            bad++;
            $display("FAIL multi_done: done@%0d, want 97", de);
        end
    endtask

    task automatic test_rd_stall();
        int ce, le, we, de;
        drive_layer(3, 1, 4, 3, 0, ce, le, we, de);
        total++;
        if (de != 16) begin
            bad++;
            $display("FAIL rd_stall_done: done@%0d, want 16", de);
        end
    endtask

    task automatic test_wr_stall();
        int ce, le, we, de;
        drive_layer(4, 1, -1, 0, 5, ce, le, we, de);
        total++;
        if (de != 54) begin
            bad++;
            $display("FAIL wr_stall_done: done@%0d, want 54", de);
        end
    endtask

    task automatic test_cfg_err();
        logic [5:0] dims [4] = '{6'd2, 6'd3, 6'd3, 6'd33};
        logic [2:0] nfs  [4] = '{3'd1, 3'd0, 3'd5, 3'd1};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_dim = dims[i]; num_filt = nfs[i]; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            total++;
            if (cfg_err !== 1'b1 || busy !== 1'b0) begin
                bad++;
                $display("FAIL cfg_err_pulse dim=%0d nf=%0d: cfg_err=%0b busy=%0b, want 1 0",
                         dims[i], nfs[i], cfg_err, busy);
            end
            @(negedge clk);
            total++;
            if (cfg_err !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL cfg_err_width dim=%0d nf=%0d: cfg_err=%0b busy=%0b, want 0 0",
                         dims[i], nfs[i], cfg_err, busy);
            end
        end
    endtask

    task automatic test_abort();
        int  wr_cnt, n, ce, le, we, de;
        bit  hit, saw_done;
        @(negedge clk);
        in_dim = 6'd5; num_filt = 3'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wr_cnt = 0; hit = 1'b0;
        for (n = 0; n < 200 && !hit; n++) begin
            if (wr_cnt == 3 && rd_valid && tap_idx == 4'd4) begin
                hit = 1'b1;
                abort = 1'b1;
            end else begin
                if (wr_valid) wr_cnt++;
            end
            @(negedge clk);
        end
        abort = 1'b0;
        total++;
        if (!hit || busy !== 1'b0 || rd_valid !== 1'b0 || wr_valid !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL abort_idle: reached=%0b busy=%0b rdv=%0b wrv=%0b done=%0b, want 1 0 0 0 0",
                     hit, busy, rd_valid, wr_valid, done);
        end
        saw_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        total++;
        if (saw_done) begin
            bad++;
            $display("FAIL abort_quiet: done/busy seen=%0b after abort, want 0", saw_done);
        end
        // abort beats a simultaneous legal start
        in_dim = 6'd5; num_filt = 3'd1; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_beats_start: busy=%0b, want 0", busy);
        end
        drive_layer(5, 1, -1, 0, 0, ce, le, we, de);
        total++;
        if (de != 109) begin
            bad++;
            $display("FAIL after_abort_done: done@%0d, want 109", de);
        end
    endtask

    task automatic test_rst_wait();
        int  n, ce, le, we, de;
        bit  hit;
        @(negedge clk);
        in_dim = 6'd3; num_filt = 3'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (n = 0; n < 50 && !hit; n++) begin
            if (busy && !rd_valid && !wr_valid && !done) begin
                hit = 1'b1;
                rst = 1'b1;
            end
            @(negedge clk);
        end
        rst = 1'b0;
        total++;
        if (!hit || busy !== 1'b0 || rd_addr !== 12'd0 || wr_addr !== 12'd0 || tap_idx !== 4'd0) begin
            bad++;
            $display("FAIL rst_in_wait: reached=%0b busy=%0b rd_addr=%0d wr_addr=%0d tap=%0d, want 1 0 0 0 0",
                     hit, busy, rd_addr, wr_addr, tap_idx);
        end
        drive_layer(3, 1, -1, 0, 0, ce, le, we, de);
        total++;
        if (de != 13) begin
            bad++;
            $display("FAIL after_rst_done: done@%0d, want 13", de);
        end
    endtask

    task automatic test_back_to_back();
        int ce, le, we, de1, de2;
        drive_layer(3, 2, -1, 0, 0, ce, le, we, de1);
        drive_layer(4, 1, -1, 0, 0, ce, le, we, de2);
        total++;
        if (de1 != 25 || de2 != 49) begin
            bad++;
            $display("FAIL back_to_back: done@%0d,%0d, want 25,49", de1, de2);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        in_dim = 6'd0; num_filt = 3'd0; rd_ready = 1'b1; wr_ready = 1'b1;
        test_reset();
        test_single_pixel();
        test_multi_filter();
        test_rd_stall();
        test_wr_stall();
        test_cfg_err();
        test_abort();
        test_rst_wait();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
